// File: rtl/axi_vram_slave.sv
// AXI4-Lite slave that bridges to an external word-addressed VRAM port.
// Build option: define AXI_VRAM_SLVERR_EN to reject out-of-range word indices with SLVERR.
module axi_vram_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int NUM_WORDS        = 601,
  parameter int RD_LATENCY       = 1
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [2:0]                      axi_awprot,
  input  logic                            axi_awvalid,
  output logic                            axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                            axi_wvalid,
  output logic                            axi_wready,
  output logic [1:0]                      axi_bresp,
  output logic                            axi_bvalid,
  input  logic                            axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [2:0]                      axi_arprot,
  input  logic                            axi_arvalid,
  output logic                            axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                      axi_rresp,
  output logic                            axi_rvalid,
  input  logic                            axi_rready,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   mem_we,
  output logic [$clog2(NUM_WORDS)-1:0]    mem_waddr,
  output logic [C_AXI_DATA_WIDTH-1:0]     mem_wdata,
  output logic                            mem_re,
  output logic [$clog2(NUM_WORDS)-1:0]    mem_raddr,
  input  logic [C_AXI_DATA_WIDTH-1:0]     mem_rdata
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int LSB    = $clog2(STRB_W);
  localparam int FULL_W = C_AXI_ADDR_WIDTH - LSB;
  localparam logic [FULL_W-1:0] NUM_IDX = FULL_W'(NUM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_VRAM_SLVERR_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [FULL_W-1:0] aw_idx_full, ar_idx_full;
  logic [FULL_W-1:0] aw_idx, idx_nx;
  logic [C_AXI_DATA_WIDTH-1:0] w_data, data_nx;
  logic [STRB_W-1:0] w_strb, strb_nx;
  logic aw_full, w_full, aw_full_nx, w_full_nx;
  logic aw_hs, w_hs, ar_hs, wr_go, wr_ok, rd_ok, rd_err;
  logic [1:0] lat_cnt;
  logic unused_ok;

  function automatic logic idx_in_range(input logic [FULL_W-1:0] idx);
    return !RANGE_CHK || (idx < NUM_IDX);
  endfunction

  assign aw_idx_full = axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB];
  assign ar_idx_full = axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
  assign unused_ok   = &{1'b0, axi_awprot, axi_arprot, axi_awaddr[LSB-1:0],
                         axi_araddr[LSB-1:0], aw_idx_full, ar_idx_full};

  assign aw_hs      = axi_awvalid && axi_awready;
  assign w_hs       = axi_wvalid && axi_wready;
  assign aw_full_nx = aw_full || aw_hs;
  assign w_full_nx  = w_full || w_hs;
  // A buffer captured on this edge is forwarded so a same-cycle AW+W issues immediately.
  assign idx_nx     = aw_hs ? aw_idx_full : aw_idx;
  assign data_nx    = w_hs ? axi_wdata : w_data;
  assign strb_nx    = w_hs ? axi_wstrb : w_strb;
  assign wr_go      = (w_state == W_IDLE) && aw_full_nx && w_full_nx;
  assign wr_ok      = idx_in_range(idx_nx);

  assign ar_hs      = axi_arvalid && axi_arready;
  assign rd_ok      = idx_in_range(ar_idx_full);
  assign mem_re     = ar_hs && rd_ok;
  assign mem_raddr  = ar_idx_full[IDX_W-1:0];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state     <= W_IDLE;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      mem_we      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_full <= aw_full_nx;
          w_full  <= w_full_nx;
          if (wr_go) begin
            w_state     <= W_MEM;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            mem_we      <= wr_ok ? strb_nx : '0;
            axi_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            axi_awready <= !aw_full_nx;
            axi_wready  <= !w_full_nx;
          end
        end
        W_MEM: begin
          mem_we     <= '0;
          axi_bvalid <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (aw_hs) aw_idx <= aw_idx_full;
    if (w_hs) begin
      w_data <= axi_wdata;
      w_strb <= axi_wstrb;
    end
    if (wr_go) begin
      mem_waddr <= idx_nx[IDX_W-1:0];
      mem_wdata <= data_nx;
    end
  end

  // Read side: lat_cnt counts edges since the AR handshake until mem_rdata is valid.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rdata   <= '0;
      rd_err      <= 1'b0;
      lat_cnt     <= 2'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            axi_arready <= 1'b0;
            rd_err      <= !rd_ok;
            lat_cnt     <= 2'd1;
            r_state     <= R_WAIT;
          end else begin
            axi_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (lat_cnt == 2'(RD_LATENCY)) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_err ? '0 : mem_rdata;
            axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_state    <= R_RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_vram_slave.sv
// Self-checking bench for axi_vram_slave: external VRAM model plus a word-array reference.
module tb_axi_vram_slave;
  localparam int NUM_WORDS = 601;
  localparam int RD_LAT    = 2;
`ifdef AXI_VRAM_SLVERR_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic clk, axi_aresetn, mem_init;
  logic [15:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
  logic [3:0] wstrb, mem_we;
  logic [1:0] bresp, rresp;
  logic [9:0] mem_waddr, mem_raddr;
  logic mem_re;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
  int aw_hs_edge = 0, w_hs_edge = 0, ar_hs_edge = 0;
  int we_cnt = 0, we_edge = 0, re_cnt = 0, re_edge = 0;
  logic [3:0] last_we;
  logic [9:0] last_waddr;
  logic [31:0] last_wdata;

  logic [31:0] vmem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd_p0, rd_p1;

  axi_vram_slave #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16), .NUM_WORDS(NUM_WORDS), .RD_LATENCY(RD_LAT)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .axi_awaddr(awaddr), .axi_awprot(3'b000), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(3'b000), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  // External memory: reads are pre-write on a shared edge, data valid RD_LAT edges later.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) vmem[i] <= init_word(i);
    end else begin
      if (mem_re) rd_p0 <= vmem[mem_raddr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) vmem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = (RD_LAT == 1) ? rd_p0 : rd_p1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) begin aw_hs_n <= aw_hs_n + 1; aw_hs_edge <= cyc + 1; end
    if (wvalid && wready)   begin w_hs_n <= w_hs_n + 1;   w_hs_edge <= cyc + 1;  end
    if (arvalid && arready) begin ar_hs_n <= ar_hs_n + 1; ar_hs_edge <= cyc + 1; end
    if (mem_we != 4'h0) begin
      we_cnt <= we_cnt + 1; we_edge <= cyc + 1;
      last_we <= mem_we; last_waddr <= mem_waddr; last_wdata <= mem_wdata;
    end
    if (mem_re) begin re_cnt <= re_cnt + 1; re_edge <= cyc + 1; end
  end

  function automatic bit addr_ok(input logic [15:0] a);
    return (RANGE_CHK == 1'b0) || ((a >> 2) < 16'(NUM_WORDS));
  endfunction

  function automatic logic [31:0] exp_read(input logic [15:0] a);
    return addr_ok(a) ? ref_mem[a[11:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [15:0] a);
    return addr_ok(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    if (addr_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit b_early, input int b_dly,
                          output logic [1:0] resp, output int bv_lat, output int bhold,
                          output int rdy_bad, output bit to);
    int aw0, w0, hs, n;
    bit awd, wd, seen;
    aw0 = aw_hs_n; w0 = w_hs_n; awd = 0; wd = 0; to = 0; rdy_bad = 0; bv_lat = -1; resp = 2'bxx;
    awaddr = addr; wdata = data; wstrb = strb; bready = b_early;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      awd = (aw_hs_n != aw0); wd = (w_hs_n != w0);
      if (awd && wd) break;
      if (wd && wready) rdy_bad++;
      if (awd && awready) rdy_bad++;
      awvalid = !awd && (c >= aw_dly);
      wvalid  = !wd && (c >= w_dly);
    end
    awvalid = 0; wvalid = 0;
    if (!(awd && wd)) to = 1;
    hs = (aw_hs_edge > w_hs_edge) ? aw_hs_edge : w_hs_edge;
    seen = 0; n = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (!seen && bvalid) begin seen = 1; bv_lat = cyc - hs; resp = bresp; end
      if (seen) begin
        if (!bvalid) break;
        if (bresp !== resp) rdy_bad++;
        if (awready || wready) rdy_bad++;
        if (n == b_dly) bready = 1;
        n++;
      end else if (awready || wready) rdy_bad++;
    end
    bready = 0; bhold = n;
    if (!seen || bvalid) to = 1;
  endtask

  task automatic do_read(input logic [15:0] addr, input int ar_dly, input bit r_early, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp, output int lat,
                         output int rhold, output int bad, output bit to);
    int ar0, n;
    bit ard, seen;
    ar0 = ar_hs_n; ard = 0; to = 0; bad = 0; lat = -1; data = 'x; resp = 'x;
    araddr = addr; rready = r_early;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      ard = (ar_hs_n != ar0);
      if (ard) break;
      arvalid = (c >= ar_dly);
    end
    arvalid = 0;
    if (!ard) to = 1;
    seen = 0; n = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (!seen && rvalid) begin seen = 1; lat = cyc - ar_hs_edge; data = rdata; resp = rresp; end
      if (seen) begin
        if (!rvalid) break;
        if (rdata !== data || rresp !== resp || arready) bad++;
        if (n == r_dly) rready = 1;
        n++;
      end else if (arready) bad++;
    end
    rready = 0; rhold = n;
    if (!seen || rvalid) to = 1;
  endtask

  task automatic test_reset();
    axi_aresetn = 0; mem_init = 1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, mem_re} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 000000",
                         {awready, wready, arready, bvalid, rvalid, mem_re});
    end
    n_checks++;
    if ({mem_we, bresp, rresp, rdata} !== 40'h0) begin
      n_fail++; $display("FAIL reset_data: we=%h bresp=%b rresp=%b rdata=%h, expected all zero",
                         mem_we, bresp, rresp, rdata);
    end
    mem_init = 0; axi_aresetn = 1; #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release_no_edge: readies=%b, expected 000", {awready, wready, arready});
    end
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_first_edge: readies=%b, expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle_aw_w();
    logic [1:0] resp; int bl, bh, rb, wc; bit to;
    wc = we_cnt;
    do_write(16'h0960, 32'h001F_6000, 4'hF, 0, 0, 0, 0, resp, bl, bh, rb, to);
    ref_write(16'h0960, 32'h001F_6000, 4'hF);
    n_checks++;
    if ({last_we, last_waddr, last_wdata} !== {4'hF, 10'd600, 32'h001F_6000} || we_cnt - wc != 1) begin
      n_fail++; $display("FAIL aww_strobe: we=%h waddr=%0d wdata=%h pulses=%0d, expected f 600 001f6000 1",
                         last_we, last_waddr, last_wdata, we_cnt - wc);
    end
    n_checks++;
    if (we_edge - aw_hs_edge != 1 || aw_hs_edge != w_hs_edge) begin
      n_fail++; $display("FAIL aww_issue_edge: we_edge-aw=%0d aw=%0d w=%0d, expected 1 and equal",
                         we_edge - aw_hs_edge, aw_hs_edge, w_hs_edge);
    end
    n_checks++;
    if (bl != 1 || resp !== 2'b00 || rb != 0 || to || bh != 1) begin
      n_fail++; $display("FAIL aww_bresp: lat=%0d resp=%b rdy_bad=%0d to=%0d hold=%0d, expected 1 00 0 0 1",
                         bl, resp, rb, to, bh);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; int bl, bh, rb, wc; bit to;
    wc = we_cnt;
    do_write(16'h0010, 32'hA5A5_A5A5, 4'hF, 3, 0, 0, 1, resp, bl, bh, rb, to);
    ref_write(16'h0010, 32'hA5A5_A5A5, 4'hF);
    n_checks++;
    if (rb != 0 || to) begin
      n_fail++; $display("FAIL wfirst_ready: rdy_bad=%0d to=%0d, expected 0 0", rb, to);
    end
    n_checks++;
    if (aw_hs_edge - w_hs_edge != 3 || we_edge - aw_hs_edge != 1 || we_cnt - wc != 1 || last_waddr !== 10'd4) begin
      n_fail++; $display("FAIL wfirst_issue: aw-w=%0d we-aw=%0d pulses=%0d waddr=%0d, expected 3 1 1 4",
                         aw_hs_edge - w_hs_edge, we_edge - aw_hs_edge, we_cnt - wc, last_waddr);
    end
    n_checks++;
    if (bl != 1 || resp !== 2'b00 || bh != 2) begin
      n_fail++; $display("FAIL wfirst_bresp: lat=%0d resp=%b hold=%0d, expected 1 00 2", bl, resp, bh);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp, rr; logic [31:0] d, ex; int bl, bh, rb, lat, rh, bad, wc; bit to, to2;
    do_write(16'h0050, 32'h1122_3344, 4'hF, 0, 0, 0, 0, resp, bl, bh, rb, to);
    ref_write(16'h0050, 32'h1122_3344, 4'hF);
    do_write(16'h0050, 32'h0000_BB00, 4'h2, 1, 0, 0, 0, resp, bl, bh, rb, to);
    ref_write(16'h0050, 32'h0000_BB00, 4'h2);
    ex = exp_read(16'h0050);
    do_read(16'h0050, 0, 0, 0, d, rr, lat, rh, bad, to2);
    n_checks++;
    if (d !== ex || rr !== 2'b00 || to || to2) begin
      n_fail++; $display("FAIL strobe_merge: got %h resp=%b, expected %h 00", d, rr, ex);
    end
    wc = we_cnt;
    ex = exp_read(16'h0060);
    do_write(16'h0060, $urandom, 4'h0, 0, 0, 0, 0, resp, bl, bh, rb, to);
    do_read(16'h0060, 0, 0, 0, d, rr, lat, rh, bad, to2);
    n_checks++;
    if (we_cnt != wc || resp !== 2'b00 || bl != 1 || d !== ex) begin
      n_fail++; $display("FAIL zero_strobe: pulses=%0d bresp=%b lat=%0d data=%h, expected 0 00 1 %h",
                         we_cnt - wc, resp, bl, d, ex);
    end
  endtask

  task automatic test_read_hold();
    logic [1:0] rr; logic [31:0] d, ex; int lat, rh, bad, rc; bit to;
    rc = re_cnt; ex = exp_read(16'h0008);
    do_read(16'h0008, 0, 0, 5, d, rr, lat, rh, bad, to);
    n_checks++;
    if (lat != RD_LAT || re_edge != ar_hs_edge || re_cnt - rc != 1) begin
      n_fail++; $display("FAIL rhold_latency: lat=%0d re_edge-ar=%0d re=%0d, expected %0d 0 1",
                         lat, re_edge - ar_hs_edge, re_cnt - rc, RD_LAT);
    end
    n_checks++;
    if (d !== ex || rr !== 2'b00 || bad != 0 || rh != 6 || to) begin
      n_fail++; $display("FAIL rhold_stable: data=%h resp=%b bad=%0d hold=%0d to=%0d, expected %h 00 0 6 0",
                         d, rr, bad, rh, to, ex);
    end
  endtask

  task automatic test_early_ready();
    logic [1:0] resp, rr; logic [31:0] d, ex; int bl, bh, rb, lat, rh, bad; bit to, to2;
    do_write(16'h0104, 32'hCAFE_F00D, 4'hF, 0, 0, 1, 0, resp, bl, bh, rb, to);
    ref_write(16'h0104, 32'hCAFE_F00D, 4'hF);
    ex = exp_read(16'h0104);
    do_read(16'h0104, 0, 1, 0, d, rr, lat, rh, bad, to2);
    n_checks++;
    if (bh != 1 || rh != 1 || bl != 1 || lat != RD_LAT || d !== ex || to || to2) begin
      n_fail++; $display("FAIL early_ready: bhold=%0d rhold=%0d blat=%0d rlat=%0d data=%h, expected 1 1 1 %0d %h",
                         bh, rh, bl, lat, d, RD_LAT, ex);
    end
  endtask

  task automatic test_read_during_write();
    logic [1:0] resp, rr; logic [31:0] d, old_v, new_v; int bl, bh, rb, lat, rh, bad; bit to, to2;
    old_v = exp_read(16'h0078);
    fork
      do_write(16'h0078, 32'h5EED_0001, 4'hF, 0, 0, 0, 0, resp, bl, bh, rb, to);
      do_read(16'h0078, 1, 0, 0, d, rr, lat, rh, bad, to2);
    join
    ref_write(16'h0078, 32'h5EED_0001, 4'hF);
    n_checks++;
    if (re_edge != we_edge || d !== old_v || to || to2) begin
      n_fail++; $display("FAIL rw_collide: re_edge=%0d we_edge=%0d data=%h, expected equal edges and %h",
                         re_edge, we_edge, d, old_v);
    end
    new_v = exp_read(16'h0078);
    do_read(16'h0078, 0, 0, 0, d, rr, lat, rh, bad, to2);
    n_checks++;
    if (d !== new_v) begin
      n_fail++; $display("FAIL rw_after: got %h, expected %h", d, new_v);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, rr; logic [31:0] d, ex; int bl, bh, rb, lat, rh, bad, wc, rc; bit to, to2;
    wc = we_cnt; rc = re_cnt;
    do_write(16'd2404, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, resp, bl, bh, rb, to);
    ref_write(16'd2404, 32'hDEAD_BEEF, 4'hF);
    ex = exp_read(16'd2404);
    do_read(16'd2404, 0, 0, 0, d, rr, lat, rh, bad, to2);
    n_checks++;
    if (resp !== exp_resp(16'd2404) || rr !== exp_resp(16'd2404) || d !== ex) begin
      n_fail++; $display("FAIL range_resp: bresp=%b rresp=%b data=%h, expected %b %b %h",
                         resp, rr, d, exp_resp(16'd2404), exp_resp(16'd2404), ex);
    end
    n_checks++;
    if (we_cnt - wc != int'(addr_ok(16'd2404)) || re_cnt - rc != int'(addr_ok(16'd2404))) begin
      n_fail++; $display("FAIL range_strobes: we=%0d re=%0d, expected %0d each",
                         we_cnt - wc, re_cnt - rc, int'(addr_ok(16'd2404)));
    end
    n_checks++;
    if (bl != 1 || lat != RD_LAT || to || to2) begin
      n_fail++; $display("FAIL range_timing: blat=%0d rlat=%0d, expected 1 %0d", bl, lat, RD_LAT);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, rr; logic [31:0] d, wd, ex; logic [15:0] a; logic [3:0] s;
    int bl, bh, rb, lat, rh, bad, bdly, rdly; bit to, to2, be, re;
    for (int it = 0; it < 40; it++) begin
      a = 16'($urandom_range(NUM_WORDS - 1, 0) << 2) | 16'($urandom_range(3, 0));
      wd = $urandom; s = 4'($urandom);
      be = 1'($urandom); bdly = be ? 0 : $urandom_range(3, 0);
      do_write(a, wd, s, $urandom_range(3, 0), $urandom_range(3, 0), be, bdly, resp, bl, bh, rb, to);
      ref_write(a, wd, s);
      n_checks++;
      if (resp !== exp_resp(a) || bl != 1 || bh != bdly + 1 || rb != 0 || to) begin
        n_fail++; $display("FAIL rand_write[%0d]: resp=%b lat=%0d hold=%0d rdy_bad=%0d, expected %b 1 %0d 0",
                           it, resp, bl, bh, rb, exp_resp(a), bdly + 1);
      end
      if (it % 3 == 0) a = 16'($urandom_range(NUM_WORDS - 1, 0) << 2);
      re = 1'($urandom); rdly = re ? 0 : $urandom_range(3, 0);
      ex = exp_read(a);
      do_read(a, $urandom_range(2, 0), re, rdly, d, rr, lat, rh, bad, to2);
      n_checks++;
      if (d !== ex || rr !== exp_resp(a) || lat != RD_LAT || rh != rdly + 1 || bad != 0 || to2) begin
        n_fail++; $display("FAIL rand_read[%0d] addr %h: data=%h resp=%b lat=%0d hold=%0d, expected %h %b %0d %0d",
                           it, a, d, rr, lat, rh, ex, exp_resp(a), RD_LAT, rdly + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; int bl, bh, rb, wc; bit to;
    @(negedge clk);
    awaddr = 16'h0100; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    ref_write(16'h0100, 32'h0BAD_0BAD, 4'hF);
    for (int c = 0; c < 10 && !bvalid; c++) @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_bvalid: got %b, expected 1", bvalid);
    end
    wc = we_cnt;
    axi_aresetn = 0; #1;
    n_checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_async: bvalid/readies=%b, expected 0000", {bvalid, awready, wready, arready});
    end
    repeat (3) @(negedge clk);
    axi_aresetn = 1;
    @(negedge clk);
    n_checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin
      n_fail++; $display("FAIL rstmid_release: bvalid/readies=%b, expected 0111", {bvalid, awready, wready, arready});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (we_cnt != wc) begin
      n_fail++; $display("FAIL rstmid_no_write: pulses=%0d, expected 0", we_cnt - wc);
    end
    // Leave an AW stranded in its buffer, reset, then check the next write uses only fresh state.
    awaddr = 16'h0200; awvalid = 1;
    @(negedge clk);
    awvalid = 0; axi_aresetn = 0;
    @(negedge clk);
    axi_aresetn = 1;
    @(negedge clk);
    wc = we_cnt;
    do_write(16'h0204, 32'h7777_1234, 4'hF, 2, 0, 0, 0, resp, bl, bh, rb, to);
    ref_write(16'h0204, 32'h7777_1234, 4'hF);
    n_checks++;
    if (we_cnt - wc != 1 || last_waddr !== 10'h081 || rb != 0 || to) begin
      n_fail++; $display("FAIL rstmid_buffers: pulses=%0d waddr=%h rdy_bad=%0d, expected 1 081 0",
                         we_cnt - wc, last_waddr, rb);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_aw_w();
    test_w_before_aw();
    test_strobes();
    test_read_hold();
    test_early_ready();
    test_read_during_write();
    test_out_of_range();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
